mem_port_arbiter: RTL and testbench

Sequential arbiter that shares one single-ported, variable-latency memory between the pipeline's instruction-fetch (IF) requester and its data-memory (MEM) requester. It sits between the IF/MEM stages of `pipeline_zsj` and the unified memory model. It schedules one transaction at a time, gives MEM priority over IF, and generates the stage stall signals. A watchdog aborts transactions the memory never completes.

---
 rtl/mem_port_arbiter.sv | 203 ++++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one single-ported, variable-latency memory between the instruction
// fetch (IF) requester and the data memory (MEM) requester. One transaction
// is in flight at a time. MEM wins when both ask from idle. At a completion
// edge the other requester is granted directly, so there is no idle bubble.
// A watchdog aborts a transaction that the memory never completes.
module mem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              resetN,
    input  logic              ifReq,
    input  logic [ADDR_W-1:0] ifAddr,
    output logic [DATA_W-1:0] ifRData,
    output logic              ifDone,
    input  logic              dReq,
    input  logic              dWe,
    input  logic [ADDR_W-1:0] dAddr,
    input  logic [DATA_W-1:0] dWData,
    output logic [DATA_W-1:0] dRData,
    output logic              dDone,
    output logic              stallIF,
    output logic              stallMEM,
    output logic              mReq,
    output logic              mWe,
    output logic [ADDR_W-1:0] mAddr,
    output logic [DATA_W-1:0] mWData,
    input  logic [DATA_W-1:0] mRData,
    input  logic              mReady,
    output logic              timeoutErr
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY_IF = 2'd1,
        BUSY_D  = 2'd2
    } state_t;

    // The abort fires on the busy edge that would bring the count to TIMEOUT.
    localparam logic [7:0] WD_LAST = 8'(TIMEOUT - 1);

    state_t              state_r, state_s;
    logic                m_req_r, m_req_s;
    logic                m_we_r, m_we_s;
    logic [ADDR_W-1:0]   m_addr_r, m_addr_s;
    logic [DATA_W-1:0]   m_wdata_r, m_wdata_s;
    logic [DATA_W-1:0]   if_rdata_r, if_rdata_s;
    logic [DATA_W-1:0]   d_rdata_r, d_rdata_s;
    logic                if_done_r, if_done_s;
    logic                d_done_r, d_done_s;
    logic                timeout_err_r, timeout_err_s;
    logic [7:0]          wd_cnt_r, wd_cnt_s;
    logic                grant_if_s;
    logic                grant_d_s;
    logic                wd_expire_s;

    // Next-state, grant, completion and watchdog decisions
    always_comb begin
        state_s       = state_r;
        m_req_s       = m_req_r;
        m_we_s        = m_we_r;
        m_addr_s      = m_addr_r;
        m_wdata_s     = m_wdata_r;
        if_rdata_s    = if_rdata_r;
        d_rdata_s     = d_rdata_r;
        if_done_s     = 1'b0;
        d_done_s      = 1'b0;
        timeout_err_s = timeout_err_r;
        wd_cnt_s      = wd_cnt_r;
        grant_if_s    = 1'b0;
        grant_d_s     = 1'b0;
        wd_expire_s   = (wd_cnt_r == WD_LAST);

        case (state_r)
            IDLE: begin
                if (dReq) begin
                    grant_d_s = 1'b1;
                end else if (ifReq) begin
                    grant_if_s = 1'b1;
                end else begin
                    m_req_s = 1'b0;
                end
            end
            BUSY_IF: begin
                if (mReady) begin
                    if_done_s  = 1'b1;
                    if_rdata_s = mRData;
                    // IF is still requesting here, so only MEM may follow
                    if (dReq) begin
                        grant_d_s = 1'b1;
                    end else begin
                        state_s = IDLE;
                        m_req_s = 1'b0;
                    end
                end else if (wd_expire_s) begin
                    if_done_s     = 1'b1;
                    if_rdata_s    = {DATA_W{1'b1}};
                    timeout_err_s = 1'b1;
                    m_req_s       = 1'b0;
                    state_s       = IDLE;
                    wd_cnt_s      = wd_cnt_r + 8'd1;
                end else begin
                    wd_cnt_s = wd_cnt_r + 8'd1;
                end
            end
            BUSY_D: begin
                if (mReady) begin
                    d_done_s = 1'b1;
                    // Writes leave the last read value visible to MEM
                    if (m_we_r) begin
                        d_rdata_s = d_rdata_r;
                    end else begin
                        d_rdata_s = mRData;
                    end
                    if (ifReq) begin
                        grant_if_s = 1'b1;
                    end else begin
                        state_s = IDLE;
                        m_req_s = 1'b0;
                    end
                end else if (wd_expire_s) begin
                    d_done_s = 1'b1;
                    if (m_we_r) begin
                        d_rdata_s = d_rdata_r;
                    end else begin
                        d_rdata_s = {DATA_W{1'b1}};
                    end
                    timeout_err_s = 1'b1;
                    m_req_s       = 1'b0;
                    state_s       = IDLE;
                    wd_cnt_s      = wd_cnt_r + 8'd1;
                end else begin
                    wd_cnt_s = wd_cnt_r + 8'd1;
                end
            end
            default: begin
                state_s = IDLE;
                m_req_s = 1'b0;
            end
        endcase

        if (grant_d_s) begin
            state_s   = BUSY_D;
            m_req_s   = 1'b1;
            m_we_s    = dWe;
            m_addr_s  = dAddr;
            m_wdata_s = dWData;
            wd_cnt_s  = 8'd0;
        end else if (grant_if_s) begin
            state_s  = BUSY_IF;
            m_req_s  = 1'b1;
            m_we_s   = 1'b0;
            m_addr_s = ifAddr;
            wd_cnt_s = 8'd0;
        end else begin
            // nothing granted this cycle; values chosen above stand
        end
    end

    // State and registered outputs; reset drops any in-flight transaction
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_r       <= IDLE;
            m_req_r       <= 1'b0;
            m_we_r        <= 1'b0;
            m_addr_r      <= {ADDR_W{1'b0}};
            m_wdata_r     <= {DATA_W{1'b0}};
            if_rdata_r    <= {DATA_W{1'b0}};
            d_rdata_r     <= {DATA_W{1'b0}};
            if_done_r     <= 1'b0;
            d_done_r      <= 1'b0;
            timeout_err_r <= 1'b0;
            wd_cnt_r      <= 8'd0;
        end else begin
            state_r       <= state_s;
            m_req_r       <= m_req_s;
            m_we_r        <= m_we_s;
            m_addr_r      <= m_addr_s;
            m_wdata_r     <= m_wdata_s;
            if_rdata_r    <= if_rdata_s;
            d_rdata_r     <= d_rdata_s;
            if_done_r     <= if_done_s;
            d_done_r      <= d_done_s;
            timeout_err_r <= timeout_err_s;
            wd_cnt_r      <= wd_cnt_s;
        end
    end

    assign mReq       = m_req_r;
    assign mWe        = m_we_r;
    assign mAddr      = m_addr_r;
    assign mWData     = m_wdata_r;
    assign ifRData    = if_rdata_r;
    assign dRData     = d_rdata_r;
    assign ifDone     = if_done_r;
    assign dDone      = d_done_r;
    assign timeoutErr = timeout_err_r;
    assign stallIF    = ifReq & ~if_done_r;
    assign stallMEM   = dReq & ~d_done_r;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed vector table, hand-written watchdog
// and reset sequences, then randomized traffic against a transaction-level
// model of two requesters and a variable-latency memory.
module tb_mem_port_arbiter;

    localparam int TMO = 15;

    logic        clk = 1'b0;
    logic        resetN;
    logic        ifReq;
    logic [31:0] ifAddr;
    logic [31:0] ifRData;
    logic        ifDone;
    logic        dReq;
    logic        dWe;
    logic [31:0] dAddr;
    logic [31:0] dWData;
    logic [31:0] dRData;
    logic        dDone;
    logic        stallIF;
    logic        stallMEM;
    logic        mReq;
    logic        mWe;
    logic [31:0] mAddr;
    logic [31:0] mWData;
    logic [31:0] mRData;
    logic        mReady;
    logic        timeoutErr;

    // Free-running clock
    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TMO)) dut (
        .clk(clk), .resetN(resetN),
        .ifReq(ifReq), .ifAddr(ifAddr), .ifRData(ifRData), .ifDone(ifDone),
        .dReq(dReq), .dWe(dWe), .dAddr(dAddr), .dWData(dWData),
        .dRData(dRData), .dDone(dDone),
        .stallIF(stallIF), .stallMEM(stallMEM),
        .mReq(mReq), .mWe(mWe), .mAddr(mAddr), .mWData(mWData),
        .mRData(mRData), .mReady(mReady), .timeoutErr(timeoutErr)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        if_req;
        logic [31:0] if_addr;
        logic        d_req;
        logic        d_we;
        logic [31:0] d_addr;
        logic [31:0] d_wdata;
        logic        m_ready;
        logic [31:0] m_rdata;
        logic        x_mreq;
        logic        x_mwe;
        logic [31:0] x_maddr;
        logic [31:0] x_mwdata;
        logic        x_ifdone;
        logic [31:0] x_ifrdata;
        logic        x_ddone;
        logic [31:0] x_drdata;
        logic        x_stallif;
        logic        x_stallmem;
    } vec_t;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } op_t;

    vec_t        vecs[14];
    op_t         d_ops[$];
    logic [31:0] if_ops[$];
    logic [31:0] mem_model[16];
    logic [31:0] ref_mem[16];
    logic [31:0] exp_drdata_g;

    // Two requesters plus a memory with random wait states; expectations come
    // from the arbitration rules applied to what was presented before each edge.
    task automatic run_traffic(input int n_each, input bit zero_wait, input bit eager);
        bit          busy, rdy_prev, pre_if, pre_d, comp_if, comp_d, bus_we;
        int          who, wait_left, grant, cyc, done_cnt, first_done, last_done;
        op_t         pre_dop, cur, nop;
        logic [31:0] pre_ifa, bus_addr, bus_wdata, if_head;
        logic [3:0]  idx;

        for (int i = 0; i < n_each; i++) begin
            idx       = 4'($urandom_range(0, 15));
            nop.we    = 1'($urandom_range(0, 1));
            nop.addr  = {26'd0, idx, 2'b00};
            nop.wdata = $urandom;
            d_ops.push_back(nop);
            idx = 4'($urandom_range(0, 15));
            if_ops.push_back({26'd0, idx, 2'b00});
        end

        busy = 1'b0; rdy_prev = 1'b0; pre_if = 1'b0; pre_d = 1'b0;
        who = 0; wait_left = 0; done_cnt = 0; first_done = -1; last_done = -1;
        pre_ifa = 32'd0; pre_dop = '{1'b0, 32'd0, 32'd0};
        bus_we = 1'b0; bus_addr = 32'd0; bus_wdata = 32'd0;

        for (cyc = 0; cyc < 3000 && (d_ops.size() > 0 || if_ops.size() > 0 || busy); cyc++) begin
            @(negedge clk);
            comp_if = busy && rdy_prev && (who == 1);
            comp_d  = busy && rdy_prev && (who == 2);
            chk("rnd ifDone", {31'd0, ifDone}, {31'd0, comp_if});
            chk("rnd dDone", {31'd0, dDone}, {31'd0, comp_d});
            chk("rnd stallIF", {31'd0, stallIF}, {31'd0, pre_if & ~comp_if});
            chk("rnd stallMEM", {31'd0, stallMEM}, {31'd0, pre_d & ~comp_d});
            if (ifDone === 1'b1 || dDone === 1'b1) begin
                done_cnt++;
                if (first_done < 0) first_done = cyc;
                last_done = cyc;
            end

            if (comp_if) begin
                if_head = if_ops.pop_front();
                chk("rnd ifRData", ifRData, ref_mem[if_head[5:2]]);
            end
            if (comp_d) begin
                cur = d_ops.pop_front();
                if (cur.we) ref_mem[cur.addr[5:2]] = cur.wdata;
                else exp_drdata_g = ref_mem[cur.addr[5:2]];
                chk("rnd dRData", dRData, exp_drdata_g);
            end

            grant = 0;
            if (busy && rdy_prev) begin
                if (bus_we) mem_model[bus_addr[5:2]] = bus_wdata;
                if (who == 2 && pre_if) grant = 1;
                else if (who == 1 && pre_d) grant = 2;
                busy = 1'b0;
            end else if (!busy) begin
                if (pre_d) grant = 2;
                else if (pre_if) grant = 1;
            end
            chk("rnd mReq", {31'd0, mReq}, {31'd0, (grant != 0) || busy});
            if (grant == 1) begin
                chk("rnd IF mAddr", mAddr, pre_ifa);
                chk("rnd IF mWe", {31'd0, mWe}, 32'd0);
            end
            if (grant == 2) begin
                chk("rnd D mAddr", mAddr, pre_dop.addr);
                chk("rnd D mWe", {31'd0, mWe}, {31'd0, pre_dop.we});
                if (pre_dop.we) chk("rnd D mWData", mWData, pre_dop.wdata);
            end
            if (grant != 0) begin
                busy      = 1'b1;
                who       = grant;
                bus_addr  = mAddr;
                bus_we    = mWe;
                bus_wdata = mWData;
                wait_left = zero_wait ? 0 : int'($urandom_range(0, 3));
            end

            if (comp_if) pre_if = 1'b0;
            if (comp_d) pre_d = 1'b0;
            if (!pre_if && if_ops.size() > 0 && (eager || $urandom_range(0, 2) != 0)) begin
                pre_if  = 1'b1;
                pre_ifa = if_ops[0];
            end
            if (!pre_d && d_ops.size() > 0 && (eager || $urandom_range(0, 2) != 0)) begin
                pre_d   = 1'b1;
                pre_dop = d_ops[0];
            end
            ifReq  = pre_if;
            ifAddr = pre_if ? pre_ifa : $urandom;
            dReq   = pre_d;
            dWe    = pre_d ? pre_dop.we : 1'b0;
            dAddr  = pre_d ? pre_dop.addr : $urandom;
            dWData = pre_d ? pre_dop.wdata : $urandom;

            if (busy) begin
                rdy_prev = (wait_left == 0);
                if (wait_left > 0) wait_left--;
                mReady = rdy_prev;
                mRData = rdy_prev ? mem_model[bus_addr[5:2]] : $urandom;
            end else begin
                rdy_prev = 1'b0;
                mReady   = 1'b0;
                mRData   = $urandom;
            end
        end

        chk("traffic drained", d_ops.size() + if_ops.size() + int'(busy), 32'd0);
        chk("done pulse count", done_cnt, 2 * n_each);
        if (eager && zero_wait) chk("back-to-back span", last_done - first_done + 1, 2 * n_each);
    endtask

    // Hard stop in case something stalls the stimulus
    initial begin
        #2000000;
        $display("FAIL sim_time_limit: got expired, required completion");
        $fatal(1);
    end

    // Main stimulus
    initial begin
        resetN = 1'b0; ifReq = 1'b0; ifAddr = 32'd0; dReq = 1'b0; dWe = 1'b0;
        dAddr = 32'd0; dWData = 32'd0; mRData = 32'd0; mReady = 1'b0;
        exp_drdata_g = 32'd0;

        // ifReq, ifAddr, dReq, dWe, dAddr, dWData, mReady, mRData |
        // mReq, mWe, mAddr, mWData, ifDone, ifRData, dDone, dRData, stallIF, stallMEM
        vecs[0]  = '{1'b1, 32'h4, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h20100005,
                     1'b1, 1'b0, 32'h4, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0};
        vecs[1]  = '{1'b1, 32'h4, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h20100005,
                     1'b0, 1'b0, 32'h4, 32'h0, 1'b1, 32'h20100005, 1'b0, 32'h0, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 32'h4, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h20100005,
                     1'b0, 1'b0, 32'h4, 32'h0, 1'b0, 32'h20100005, 1'b0, 32'h0, 1'b0, 1'b0};
        vecs[3]  = '{1'b1, 32'hC, 1'b1, 1'b1, 32'h8, 32'hABCD, 1'b0, 32'h0,
                     1'b1, 1'b1, 32'h8, 32'hABCD, 1'b0, 32'h20100005, 1'b0, 32'h0, 1'b1, 1'b1};
        vecs[4]  = vecs[3];
        vecs[5]  = vecs[3];
        vecs[6]  = '{1'b1, 32'hC, 1'b1, 1'b1, 32'h8, 32'hABCD, 1'b1, 32'hDEAD0000,
                     1'b1, 1'b0, 32'hC, 32'hABCD, 1'b0, 32'h20100005, 1'b1, 32'h0, 1'b1, 1'b0};
        vecs[7]  = '{1'b1, 32'hC, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0,
                     1'b1, 1'b0, 32'hC, 32'hABCD, 1'b0, 32'h20100005, 1'b0, 32'h0, 1'b1, 1'b0};
        vecs[8]  = vecs[7];
        vecs[9]  = vecs[7];
        vecs[10] = '{1'b1, 32'hC, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h12345678,
                     1'b0, 1'b0, 32'hC, 32'hABCD, 1'b1, 32'h12345678, 1'b0, 32'h0, 1'b0, 1'b0};
        vecs[11] = '{1'b0, 32'h0, 1'b1, 1'b0, 32'h10, 32'h0, 1'b1, 32'hCAFEF00D,
                     1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 32'h12345678, 1'b0, 32'h0, 1'b0, 1'b1};
        vecs[12] = '{1'b0, 32'h0, 1'b1, 1'b0, 32'h10, 32'h0, 1'b1, 32'hCAFEF00D,
                     1'b0, 1'b0, 32'h10, 32'h0, 1'b0, 32'h12345678, 1'b1, 32'hCAFEF00D, 1'b0, 1'b0};
        vecs[13] = '{1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0,
                     1'b0, 1'b0, 32'h10, 32'h0, 1'b0, 32'h12345678, 1'b0, 32'hCAFEF00D, 1'b0, 1'b0};

        // Reset state
        #1;
        chk("reset mReq", {31'd0, mReq}, 32'd0);
        chk("reset mAddr", mAddr, 32'd0);
        chk("reset ifDone", {31'd0, ifDone}, 32'd0);
        chk("reset dRData", dRData, 32'd0);
        chk("reset timeoutErr", {31'd0, timeoutErr}, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        resetN = 1'b1;

        // Directed vector table
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            ifReq = vecs[i].if_req; ifAddr = vecs[i].if_addr;
            dReq = vecs[i].d_req; dWe = vecs[i].d_we;
            dAddr = vecs[i].d_addr; dWData = vecs[i].d_wdata;
            mReady = vecs[i].m_ready; mRData = vecs[i].m_rdata;
            @(posedge clk);
            #1;
            chk($sformatf("v%0d mReq", i), {31'd0, mReq}, {31'd0, vecs[i].x_mreq});
            chk($sformatf("v%0d mWe", i), {31'd0, mWe}, {31'd0, vecs[i].x_mwe});
            chk($sformatf("v%0d mAddr", i), mAddr, vecs[i].x_maddr);
            chk($sformatf("v%0d mWData", i), mWData, vecs[i].x_mwdata);
            chk($sformatf("v%0d ifDone", i), {31'd0, ifDone}, {31'd0, vecs[i].x_ifdone});
            chk($sformatf("v%0d ifRData", i), ifRData, vecs[i].x_ifrdata);
            chk($sformatf("v%0d dDone", i), {31'd0, dDone}, {31'd0, vecs[i].x_ddone});
            chk($sformatf("v%0d dRData", i), dRData, vecs[i].x_drdata);
            chk($sformatf("v%0d stallIF", i), {31'd0, stallIF}, {31'd0, vecs[i].x_stallif});
            chk($sformatf("v%0d stallMEM", i), {31'd0, stallMEM}, {31'd0, vecs[i].x_stallmem});
        end

        // Watchdog on an IF read that never completes
        @(negedge clk);
        ifReq = 1'b1; ifAddr = 32'h40; mReady = 1'b0;
        @(posedge clk);
        #1;
        chk("wd grant mReq", {31'd0, mReq}, 32'd1);
        for (int k = 1; k <= TMO; k++) begin
            @(posedge clk);
            #1;
            chk($sformatf("wd edge%0d ifDone", k), {31'd0, ifDone}, {31'd0, k == TMO});
            chk($sformatf("wd edge%0d timeoutErr", k), {31'd0, timeoutErr}, {31'd0, k == TMO});
        end
        chk("wd ifRData", ifRData, 32'hFFFFFFFF);
        chk("wd mReq", {31'd0, mReq}, 32'd0);
        @(negedge clk);
        ifReq = 1'b0;
        @(posedge clk);
        #1;
        chk("wd done one cycle", {31'd0, ifDone}, 32'd0);
        repeat (100) @(posedge clk);
        #1;
        chk("wd sticky timeoutErr", {31'd0, timeoutErr}, 32'd1);

        // Reset in the middle of a MEM write
        @(negedge clk);
        dReq = 1'b1; dWe = 1'b1; dAddr = 32'h80; dWData = 32'h5A5A; mReady = 1'b0;
        @(posedge clk);
        #1;
        chk("rst grant mWe", {31'd0, mWe}, 32'd1);
        @(negedge clk);
        resetN = 1'b0;
        #1;
        chk("rst mReq", {31'd0, mReq}, 32'd0);
        chk("rst mWe", {31'd0, mWe}, 32'd0);
        chk("rst mAddr", mAddr, 32'd0);
        chk("rst mWData", mWData, 32'd0);
        chk("rst ifRData", ifRData, 32'd0);
        chk("rst dRData", dRData, 32'd0);
        chk("rst timeoutErr", {31'd0, timeoutErr}, 32'd0);
        dReq = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst no dDone", {31'd0, dDone}, 32'd0);
        @(negedge clk);
        resetN = 1'b1; ifReq = 1'b1; ifAddr = 32'h44; mReady = 1'b1; mRData = 32'h55AA1234;
        @(posedge clk);
        #1;
        chk("post-rst mAddr", mAddr, 32'h44);
        chk("post-rst early ifDone", {31'd0, ifDone}, 32'd0);
        @(posedge clk);
        #1;
        chk("post-rst ifDone", {31'd0, ifDone}, 32'd1);
        chk("post-rst ifRData", ifRData, 32'h55AA1234);
        chk("post-rst stallIF", {31'd0, stallIF}, 32'd0);
        @(negedge clk);
        ifReq = 1'b0; mReady = 1'b0;
        @(posedge clk);
        #1;
        chk("post-rst idle mReq", {31'd0, mReq}, 32'd0);

        // Randomized traffic against the model
        for (int i = 0; i < 16; i++) begin
            mem_model[i] = $urandom;
            ref_mem[i]   = mem_model[i];
        end
        exp_drdata_g = 32'd0;
        run_traffic(30, 1'b0, 1'b0);
        run_traffic(20, 1'b1, 1'b1);
        chk("final timeoutErr", {31'd0, timeoutErr}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
